// File: rtl/event_latch8_pkg.sv
// Shared definitions for the event latch: line count, index width and FSM state encodings.
package event_latch8_pkg;

  localparam int LINES     = 8;
  localparam int IDX_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/event_latch8_if.sv
// Event/handshake bundle between the event producer/consumer side and the latch.
interface event_latch8_if;
  import event_latch8_pkg::*;

  logic [LINES-1:0]     in;
  logic [LINES-1:0]     mask;
  logic                 ack;
  logic [LINES-1:0]     pending;
  logic                 any;
  logic                 valid;
  logic [IDX_WIDTH-1:0] idx;

  modport master (
    output in, mask, ack,
    input  pending, any, valid, idx
  );

  modport slave (
    input  in, mask, ack,
    output pending, any, valid, idx
  );

endinterface

// File: rtl/event_latch8_or8way.sv
// Eight-input OR gate used for the request reduction.
module Or8Way (
  input  logic [7:0] a,
  output logic       y
);

  assign y = |a;

endmodule

// File: rtl/event_latch8_priority_enc8.sv
// Lowest-set-bit encoder: bit 0 has highest priority, found flags a nonzero input.
module priority_enc8
  import event_latch8_pkg::*;
(
  input  logic [LINES-1:0]     vec,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 found
);

  // Scanning from the top down lets the lowest set bit overwrite the others.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IDX_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_latch8.sv
// Sticky 8-line event latch that presents the lowest masked pending event to a
// consumer over a four-phase valid/ack handshake.
module event_latch8
  import event_latch8_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  event_latch8_if.slave bus
);

  state_t               state;
  logic [LINES-1:0]     pending;
  logic [LINES-1:0]     masked;
  logic [LINES-1:0]     clear_bits;
  logic                 valid;
  logic [IDX_WIDTH-1:0] idx;
  logic [IDX_WIDTH-1:0] enc_idx;
  logic                 found;
  logic                 any;

  assign masked = pending & bus.mask;

  Or8Way u_any (
    .a (masked),
    .y (any)
  );

  priority_enc8 u_enc (
    .vec   (masked),
    .index (enc_idx),
    .found (found)
  );

  always_comb begin
    clear_bits = '0;
    if (state == REQ && bus.ack) begin
      clear_bits[idx] = 1'b1;
    end
  end

  // New events are OR'd in after the clear so a same-edge set is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
      state   <= IDLE;
      valid   <= 1'b0;
      idx     <= '0;
    end else begin
      pending <= (pending & ~clear_bits) | bus.in;
      unique case (state)
        IDLE: begin
          if (found) begin
            state <= REQ;
            valid <= 1'b1;
            idx   <= enc_idx;
          end
        end
        REQ: begin
          if (bus.ack) begin
            state <= DONE;
            valid <= 1'b0;
          end
        end
        DONE: begin
          if (!bus.ack) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pending = pending;
  assign bus.any     = any;
  assign bus.valid   = valid;
  assign bus.idx     = idx;

endmodule

// File: tb/tb_event_latch8.sv
// Directed self-checking bench for event_latch8 with hand-computed expectations.
module tb_event_latch8;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  event_latch8_if bus ();

  event_latch8 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] in_v, input logic [7:0] mask_v,
                               input logic ack_v);
    bus.in   = in_v;
    bus.mask = mask_v;
    bus.ack  = ack_v;
  endtask

  // Entered in REQ: checks the presented index, completes the handshake and
  // leaves the block one edge after DONE->IDLE (i.e. in REQ again if work remains).
  task automatic serviceOne(input logic [2:0] exp_idx, input logic [7:0] exp_after,
                            input logic [7:0] mask_v);
    checkOutput("svc_valid", {7'd0, bus.valid}, 8'd1);
    checkOutput("svc_idx", {5'd0, bus.idx}, {5'd0, exp_idx});
    applyStimulus(8'h00, mask_v, 1'b1);
    tick();
    checkOutput("svc_clear", bus.pending, exp_after);
    checkOutput("svc_drop", {7'd0, bus.valid}, 8'd0);
    applyStimulus(8'h00, mask_v, 1'b0);
    tick();
    checkOutput("svc_done_valid", {7'd0, bus.valid}, 8'd0);
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 1'b0);

    tick();
    checkOutput("rst1_pending", bus.pending, 8'h00);
    checkOutput("rst1_valid", {7'd0, bus.valid}, 8'd0);
    checkOutput("rst1_any", {7'd0, bus.any}, 8'd0);
    tick();
    checkOutput("rst2_pending", bus.pending, 8'h00);
    checkOutput("rst2_valid", {7'd0, bus.valid}, 8'd0);
    checkOutput("rst2_any", {7'd0, bus.any}, 8'd0);
    checkOutput("rst2_idx", {5'd0, bus.idx}, 8'd0);

    // Single event straight after reset release.
    reset = 1'b0;
    applyStimulus(8'h10, 8'hFF, 1'b0);
    tick();
    checkOutput("single_pending", bus.pending, 8'h10);
    checkOutput("single_any", {7'd0, bus.any}, 8'd1);
    checkOutput("single_valid_early", {7'd0, bus.valid}, 8'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();
    serviceOne(3'd4, 8'h00, 8'hFF);
    checkOutput("single_idle_valid", {7'd0, bus.valid}, 8'd0);
    checkOutput("single_idle_any", {7'd0, bus.any}, 8'd0);

    // Priority and index freeze.
    applyStimulus(8'h26, 8'hFF, 1'b0);
    tick();
    checkOutput("prio_pending", bus.pending, 8'h26);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();
    checkOutput("prio_idx", {5'd0, bus.idx}, 8'd1);
    applyStimulus(8'h01, 8'h00, 1'b0);
    tick();
    checkOutput("freeze_pending", bus.pending, 8'h27);
    checkOutput("freeze_idx", {5'd0, bus.idx}, 8'd1);
    checkOutput("freeze_valid", {7'd0, bus.valid}, 8'd1);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();
    serviceOne(3'd1, 8'h25, 8'hFF);
    serviceOne(3'd0, 8'h24, 8'hFF);
    serviceOne(3'd2, 8'h20, 8'hFF);
    serviceOne(3'd5, 8'h00, 8'hFF);
    checkOutput("prio_end_valid", {7'd0, bus.valid}, 8'd0);

    // Set wins over clear on the ack edge.
    applyStimulus(8'h08, 8'hFF, 1'b0);
    tick();
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();
    checkOutput("setwin_idx", {5'd0, bus.idx}, 8'd3);
    applyStimulus(8'h08, 8'hFF, 1'b1);
    tick();
    checkOutput("setwin_pending", bus.pending, 8'h08);
    checkOutput("setwin_valid", {7'd0, bus.valid}, 8'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();
    tick();
    serviceOne(3'd3, 8'h00, 8'hFF);

    // Masked-only pending bit, then unmask.
    applyStimulus(8'h01, 8'h00, 1'b0);
    tick();
    checkOutput("mask_pending", bus.pending, 8'h01);
    checkOutput("mask_any", {7'd0, bus.any}, 8'd0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    tick();
    checkOutput("mask_valid", {7'd0, bus.valid}, 8'd0);
    applyStimulus(8'h00, 8'h01, 1'b0);
    #1;
    checkOutput("unmask_any", {7'd0, bus.any}, 8'd1);
    tick();
    checkOutput("unmask_valid", {7'd0, bus.valid}, 8'd1);
    checkOutput("unmask_idx", {5'd0, bus.idx}, 8'd0);

    // Reset while in DONE with ack held high and a same-edge event.
    applyStimulus(8'h00, 8'h01, 1'b1);
    tick();
    checkOutput("done_pending", bus.pending, 8'h00);
    reset = 1'b1;
    applyStimulus(8'h04, 8'hFF, 1'b1);
    tick();
    checkOutput("midrst_pending", bus.pending, 8'h00);
    checkOutput("midrst_valid", {7'd0, bus.valid}, 8'd0);
    reset = 1'b0;
    applyStimulus(8'h02, 8'h00, 1'b1);
    tick();
    checkOutput("postrst_pending", bus.pending, 8'h02);
    applyStimulus(8'h00, 8'h00, 1'b1);
    tick();
    checkOutput("postrst_noclear", bus.pending, 8'h02);
    checkOutput("postrst_valid", {7'd0, bus.valid}, 8'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();
    checkOutput("postrst_req_valid", {7'd0, bus.valid}, 8'd1);
    checkOutput("postrst_req_idx", {5'd0, bus.idx}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
